// File: rtl/dice_roller_n.sv
// Parametrised electronic dice: debounced roll button, minimum roll length,
// per-die hold, odometer-style advance, registered sum with a one-cycle strobe.
module dice_roller_n #(
  parameter int NUM_DICE        = 2,
  parameter int FACES           = 6,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_ROLL_CYCLES = 8,
  localparam int W              = $clog2(FACES + 1),
  localparam int SW             = $clog2(NUM_DICE * FACES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic [NUM_DICE-1:0]   hold_mask,
  output logic [NUM_DICE*W-1:0] throw,
  output logic [SW-1:0]         sum,
  output logic                  rolling,
  output logic                  result_valid
);

  localparam int DCW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCW = $clog2(MIN_ROLL_CYCLES + 1);

  localparam logic [DCW-1:0]        DB_LAST   = DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0]        ROLL_SAT  = RCW'(MIN_ROLL_CYCLES);
  localparam logic [RCW-1:0]        ROLL_LAST = RCW'(MIN_ROLL_CYCLES - 1);
  localparam logic [W-1:0]          FACE_MAX  = W'(FACES);
  localparam logic [W-1:0]          FACE_MIN  = W'(1);
  localparam logic [NUM_DICE*W-1:0] ALL_ONES  = {NUM_DICE{FACE_MIN}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROLL,
    S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  btn_db_q, btn_db_d;
  logic [DCW-1:0]        db_cnt_q, db_cnt_d;
  logic [RCW-1:0]        roll_cnt_q, roll_cnt_d;
  logic [NUM_DICE*W-1:0] throw_q, throw_d;
  logic [SW-1:0]         sum_q, sum_d;
  logic                  rolling_q, rolling_d;
  logic                  result_valid_q, result_valid_d;

  logic [NUM_DICE*W-1:0] throw_step;
  logic [SW-1:0]         throw_sum;
  logic [W-1:0]          die;
  logic                  carry;

  // Debouncer: btn_db only follows button after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    btn_db_d = btn_db_q;
    db_cnt_d = '0;
    if (button != btn_db_q) begin
      if (db_cnt_q == DB_LAST) btn_db_d = button;
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // NOTE: carry is a blocking ripple through the loop; each unheld die sees the
  // carry left by the unheld dice below it, and held dice pass it through untouched.
  always_comb begin
    throw_step = throw_q;
    carry      = 1'b1;
    die        = '0;
    for (int i = 0; i < NUM_DICE; i++) begin
      die = throw_q[i*W +: W];
      if (!hold_mask[i] && carry) begin
        throw_step[i*W +: W] = (die == FACE_MAX) ? FACE_MIN : die + 1'b1;
        carry                = (die == FACE_MAX);
      end
    end
  end

  always_comb begin
    throw_sum = '0;
    for (int i = 0; i < NUM_DICE; i++) throw_sum = throw_sum + SW'(throw_q[i*W +: W]);
  end

  always_comb begin
    state_d        = state_q;
    roll_cnt_d     = roll_cnt_q;
    throw_d        = throw_q;
    sum_d          = sum_q;
    result_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn_db_q) begin
          state_d    = S_ROLL;
          roll_cnt_d = '0;
        end
      end
      S_ROLL: begin
        throw_d = throw_step;
        if (roll_cnt_q != ROLL_SAT) roll_cnt_d = roll_cnt_q + 1'b1;
        if (!btn_db_q && roll_cnt_q >= ROLL_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        sum_d          = throw_sum;
        result_valid_d = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    rolling_d = (state_d == S_ROLL);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      btn_db_q       <= 1'b0;
      db_cnt_q       <= '0;
      roll_cnt_q     <= '0;
      throw_q        <= ALL_ONES;
      sum_q          <= SW'(NUM_DICE);
      rolling_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      btn_db_q       <= btn_db_d;
      db_cnt_q       <= db_cnt_d;
      roll_cnt_q     <= roll_cnt_d;
      throw_q        <= throw_d;
      sum_q          <= sum_d;
      rolling_q      <= rolling_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign throw        = throw_q;
  assign sum          = sum_q;
  assign rolling      = rolling_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_dice_roller_n.sv
// Directed bench for dice_roller_n with default parameters (2 dice, 6 faces,
// debounce 4, minimum roll 8); expected values are hand-computed.
module tb_dice_roller_n;

  logic       clk;
  logic       rst;
  logic       button;
  logic [1:0] hold_mask;
  logic [5:0] throw;
  logic [3:0] sum;
  logic       rolling;
  logic       result_valid;

  int vectors;
  int miscompares;
  int roll_cycles;
  int rv_count;
  int rv_sum;
  int rv_die0;
  int rv_die1;

  dice_roller_n dut (
    .clk          (clk),
    .rst          (rst),
    .button       (button),
    .hold_mask    (hold_mask),
    .throw        (throw),
    .sum          (sum),
    .rolling      (rolling),
    .result_valid (result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Runs n cycles, counting rolling cycles and result strobes; stops the button after press_len.
  task automatic run_monitor(input int n, input int press_len);
    roll_cycles = 0;
    rv_count    = 0;
    rv_sum      = -1;
    rv_die0     = -1;
    rv_die1     = -1;
    for (int i = 0; i < n; i++) begin
      if (i == press_len) button = 1'b0;
      tick();
      if (rolling) roll_cycles++;
      if (result_valid) begin
        rv_count++;
        rv_sum  = int'(sum);
        rv_die0 = int'(throw[2:0]);
        rv_die1 = int'(throw[5:3]);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    button      = 1'b1;
    hold_mask   = 2'b00;
    @(negedge clk);

    // 1. Reset held two cycles with the button pressed
    tick();
    tick();
    check("reset_die0", throw[2:0], 1);
    check("reset_die1", throw[5:3], 1);
    check("reset_sum", sum, 2);
    check("reset_rolling", rolling, 0);
    check("reset_rv", result_valid, 0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("debounce_not_yet", rolling, 0);
    tick();
    check("debounce_roll_starts", rolling, 1);
    rst    = 1'b0;
    button = 1'b0;
    tick();
    rst = 1'b1;

    // 2. Three-cycle glitch is filtered
    button = 1'b1;
    run_monitor(20, 3);
    check("glitch_rolling", roll_cycles, 0);
    check("glitch_rv", rv_count, 0);
    check("glitch_die0", throw[2:0], 1);
    check("glitch_die1", throw[5:3], 1);

    // 3. Long roll of 20 ROLL cycles: die0=3, die1=4
    button = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) check("long_rolling_rise", rolling, 1);
    end
    button = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("long_still_rolling", rolling, 1);
    tick();
    check("long_done_rolling", rolling, 0);
    check("long_done_rv", result_valid, 0);
    check("long_die0", throw[2:0], 3);
    check("long_die1", throw[5:3], 4);
    tick();
    check("long_rv", result_valid, 1);
    check("long_sum", sum, 7);
    tick();
    check("long_rv_single", result_valid, 0);
    check("long_sum_held", sum, 7);

    // 4. Short tap still rolls the minimum 8 cycles: {3,2}, sum 5
    rst = 1'b0;
    tick();
    rst    = 1'b1;
    button = 1'b1;
    run_monitor(30, 5);
    check("tap_roll_cycles", roll_cycles, 8);
    check("tap_rv_count", rv_count, 1);
    check("tap_sum", rv_sum, 5);
    check("tap_die0", throw[2:0], 3);
    check("tap_die1", throw[5:3], 2);

    // 5. Die 0 held: die1 takes every step and ends at 3, sum 4
    rst = 1'b0;
    tick();
    rst       = 1'b1;
    hold_mask = 2'b01;
    button    = 1'b1;
    run_monitor(30, 5);
    check("hold_roll_cycles", roll_cycles, 8);
    check("hold_rv_count", rv_count, 1);
    check("hold_sum", rv_sum, 4);
    check("hold_die0", throw[2:0], 1);
    check("hold_die1", throw[5:3], 3);

    // 5b. All dice held: sequence still completes with frozen values {1,3}
    hold_mask = 2'b11;
    button    = 1'b1;
    run_monitor(30, 5);
    check("allheld_roll_cycles", roll_cycles, 8);
    check("allheld_rv_count", rv_count, 1);
    check("allheld_rv_die0", rv_die0, 1);
    check("allheld_rv_die1", rv_die1, 3);
    check("allheld_sum", rv_sum, 4);

    // 5c. Die 1 held from {1,3}: 8 steps on die0 only, 1 -> 3
    hold_mask = 2'b10;
    button    = 1'b1;
    run_monitor(30, 5);
    check("hold1_rv_count", rv_count, 1);
    check("hold1_die0", throw[2:0], 3);
    check("hold1_die1", throw[5:3], 3);
    check("hold1_sum", rv_sum, 6);
    hold_mask = 2'b00;

    // 6. Reset in the middle of a roll aborts it without a strobe
    button = 1'b1;
    for (int i = 0; i < 20 && !rolling; i++) tick();
    check("abort_roll_started", rolling, 1);
    tick();
    tick();
    rst    = 1'b0;
    button = 1'b0;
    tick();
    check("abort_die0", throw[2:0], 1);
    check("abort_die1", throw[5:3], 1);
    check("abort_sum", sum, 2);
    check("abort_rolling", rolling, 0);
    check("abort_rv", result_valid, 0);
    rst = 1'b1;
    run_monitor(30, 0);
    check("abort_no_rv", rv_count, 0);
    check("abort_no_roll", roll_cycles, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
